// File: rtl/pipeline_exec_controller.sv
// Execution sequencer for the 5-stage pipeline: gates the global enable for run/step/drain,
// flushes for a new program and counts enabled cycles.
module pipeline_exec_controller #(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_detected,
  output logic              o_pipe_enable,
  output logic              o_pipe_flush,
  output logic              o_done,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NB_DRAIN-1:0] r_drain_cnt;
  logic [NB_DRAIN-1:0] w_drain_next;
  logic                r_done;
  logic                w_done_next;
  logic [NB_CNT-1:0]   r_cycle_count;
  logic                w_accept;
  logic                w_halt;

  assign o_pipe_enable = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
  assign o_cmd_ready   = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_HALTED);
  assign o_pipe_flush  = (r_state == S_FLUSH);
  assign o_halted      = (r_state == S_HALTED);
  assign o_done        = r_done;
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle_count;

  // A HALT seen while the pipeline is frozen is stale and must not start a drain.
  assign w_accept = i_cmd_valid & o_cmd_ready;
  assign w_halt   = i_halt_detected & o_pipe_enable;

  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmd)
            CMD_RUN:   w_state_next = S_RUN;
            CMD_STEP:  w_state_next = S_STEP;
            CMD_CLEAR: w_state_next = S_FLUSH;
            default:   w_state_next = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (w_halt) begin
          w_state_next = S_DRAIN;
          w_drain_next = DRAIN_LOAD;
        end else if (w_accept && i_cmd == CMD_ABORT) begin
          w_state_next = S_IDLE;
        end
      end
      S_STEP: begin
        if (w_halt) begin
          w_state_next = S_DRAIN;
          w_drain_next = DRAIN_LOAD;
        end else begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_next = S_HALTED;
          w_done_next  = 1'b1;
        end else begin
          w_drain_next = r_drain_cnt - 1'b1;
        end
      end
      S_HALTED: begin
        if (w_accept && i_cmd == CMD_CLEAR) w_state_next = S_FLUSH;
      end
      S_FLUSH:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_drain_cnt   <= '0;
      r_done        <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      r_done      <= w_done_next;
      if (r_state == S_FLUSH) begin
        r_cycle_count <= '0;
      end else if (o_pipe_enable && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller: a cycle model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_pipeline_exec_controller;

  localparam int NB  = 4;
  localparam int DC  = 4;
  localparam int MAXC = (1 << NB) - 1;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic [1:0]    i_cmd = 2'b00;
  logic          i_halt_detected = 1'b0;
  logic          o_cmd_ready;
  logic          o_pipe_enable;
  logic          o_pipe_flush;
  logic          o_done;
  logic          o_halted;
  logic [2:0]    o_state;
  logic [NB-1:0] o_cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_en     = 0;
  int en_base  = 0;

  // Model: mode uses the published state codes; counts tracked as plain integers.
  int m_mode  = 0;
  int m_drain = 0;
  int m_count = 0;
  int m_done  = 0;

  pipeline_exec_controller #(.NB_CNT(NB), .DRAIN_CYCLES(DC)) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_cmd_valid     (i_cmd_valid),
    .i_cmd           (i_cmd),
    .o_cmd_ready     (o_cmd_ready),
    .i_halt_detected (i_halt_detected),
    .o_pipe_enable   (o_pipe_enable),
    .o_pipe_flush    (o_pipe_flush),
    .o_done          (o_done),
    .o_halted        (o_halted),
    .o_state         (o_state),
    .o_cycle_count   (o_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    $display("cmd %0d issued at %0t, state %0d ready %0d", c, $time, o_state, o_cmd_ready);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    int nm;
    int nd;
    bit en;
    bit rdy;
    bit acc;
    bit hlt;
    if (i_reset) begin
      m_mode = 0; m_drain = 0; m_count = 0; m_done = 0;
    end
    en  = (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
    rdy = (m_mode == 0) || (m_mode == 1) || (m_mode == 4);
    chk("m_state",  32'(o_state),       32'(m_mode));
    chk("m_ready",  32'(o_cmd_ready),   32'(rdy));
    chk("m_enable", 32'(o_pipe_enable), 32'(en));
    chk("m_flush",  32'(o_pipe_flush),  32'(m_mode == 5));
    chk("m_halted", 32'(o_halted),      32'(m_mode == 4));
    chk("m_done",   32'(o_done),        32'(m_done));
    chk("m_count",  32'(o_cycle_count), 32'(m_count));
    if (o_pipe_enable) n_en++;
    if (!i_reset) begin
      acc = i_cmd_valid && rdy;
      hlt = i_halt_detected && en;
      nm  = m_mode;
      nd  = 0;
      if (m_mode == 5) m_count = 0;
      else if (en) m_count = (m_count >= MAXC) ? MAXC : m_count + 1;
      if (m_mode == 0) begin
        if (acc && i_cmd == C_RUN)   nm = 1;
        if (acc && i_cmd == C_STEP)  nm = 2;
        if (acc && i_cmd == C_CLEAR) nm = 5;
      end else if (m_mode == 1 || m_mode == 2) begin
        if (hlt) begin
          nm = 3; m_drain = DC;
        end else if (m_mode == 2) begin
          nm = 0; nd = 1;
        end else if (acc && i_cmd == C_ABORT) begin
          nm = 0;
        end
      end else if (m_mode == 3) begin
        m_drain = m_drain - 1;
        if (m_drain == 0) begin
          nm = 4; nd = 1;
        end
      end else if (m_mode == 4) begin
        if (acc && i_cmd == C_CLEAR) nm = 5;
      end else begin
        nm = 0;
      end
      m_mode = nm;
      m_done = nd;
    end
  end

  initial begin
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    chk("rst_state", 32'(o_state), 0);
    chk("rst_ready", 32'(o_cmd_ready), 1);
    chk("rst_count", 32'(o_cycle_count), 0);

    en_base = n_en;
    for (int i = 0; i < 3; i++) begin
      send(C_STEP);
      chk("step_en", 32'(o_pipe_enable), 1);
      tick();
      chk("step_done", 32'(o_done), 1);
      chk("step_idle", 32'(o_state), 0);
    end
    chk("step_count", 32'(o_cycle_count), 3);
    chk("step_pulses", 32'(n_en - en_base), 3);

    send(C_CLEAR);
    chk("clr_flush", 32'(o_pipe_flush), 1);
    tick();
    chk("clr_count", 32'(o_cycle_count), 0);

    en_base = n_en;
    send(C_RUN);
    repeat (9) tick();
    i_halt_detected = 1'b1;
    tick();
    i_halt_detected = 1'b0;
    chk("halt_drain", 32'(o_state), 3);
    repeat (3) tick();
    chk("drain_last_en", 32'(o_pipe_enable), 1);
    tick();
    chk("halt_done", 32'(o_done), 1);
    chk("halt_halted", 32'(o_halted), 1);
    chk("halt_count", 32'(o_cycle_count), 14);
    chk("halt_en_cycles", 32'(n_en - en_base), 14);
    tick();
    chk("halt_done_pulse", 32'(o_done), 0);

    send(C_RUN);
    chk("halted_run_ignored", 32'(o_state), 4);
    send(C_CLEAR);
    chk("flush_state", 32'(o_state), 5);
    chk("flush_out", 32'(o_pipe_flush), 1);
    tick();
    chk("flush_idle", 32'(o_state), 0);
    chk("flush_count", 32'(o_cycle_count), 0);

    send(C_RUN);
    repeat (2) tick();
    send(C_ABORT);
    chk("abort_idle", 32'(o_state), 0);
    chk("abort_count", 32'(o_cycle_count), 3);
    repeat (3) tick();
    chk("abort_frozen", 32'(o_cycle_count), 3);

    send(C_RUN);
    tick();
    i_cmd_valid = 1'b1;
    i_cmd = C_ABORT;
    i_halt_detected = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_halt_detected = 1'b0;
    chk("prio_drain", 32'(o_state), 3);
    repeat (4) tick();
    chk("prio_halted", 32'(o_halted), 1);

    send(C_CLEAR);
    tick();
    send(C_RUN);
    repeat (20) tick();
    send(C_ABORT);
    chk("sat_count", 32'(o_cycle_count), 15);
    tick();
    chk("sat_hold", 32'(o_cycle_count), 15);

    i_cmd_valid = 1'b1;
    i_cmd = C_STEP;
    tick();
    chk("held_in_step", 32'(o_state), 2);
    chk("held_not_ready", 32'(o_cmd_ready), 0);
    tick();
    chk("held_idle", 32'(o_state), 0);
    chk("held_ready", 32'(o_cmd_ready), 1);
    tick();
    chk("held_accepted", 32'(o_state), 2);
    i_cmd_valid = 1'b0;
    tick();
    chk("held_done", 32'(o_done), 1);

    send(C_RUN);
    tick();
    #2 i_reset = 1'b1;
    #1;
    chk("async_state", 32'(o_state), 0);
    chk("async_ready", 32'(o_cmd_ready), 1);
    chk("async_enable", 32'(o_pipe_enable), 0);
    chk("async_count", 32'(o_cycle_count), 0);
    tick();
    i_reset = 1'b0;
    tick();
    chk("post_rst_state", 32'(o_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
